// File: rtl/credential_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : credential_pkg
//  Description : Shared constants, state encoding and helpers for the
//                credential entry front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package credential_pkg;

    localparam int DIGIT_W    = 4;
    localparam int SLOTS      = 8;
    localparam int USER_SLOTS = SLOTS / 2;
    localparam int CNT_W      = 4;

    localparam logic [1:0] USER = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    // State is a pure function of the committed digit count.
    function automatic logic [1:0] state_of(input logic [CNT_W-1:0] cnt);
        if (cnt < CNT_W'(USER_SLOTS))
            return USER;
        else if (cnt < CNT_W'(SLOTS))
            return PASS;
        else
            return FULL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/credential_entry_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Raw button -> 2-flop synchronizer -> optional debounce ->
//                registered rising-edge pulse (one pulse per press).
//                Debounce is built only when CREDENTIAL_ENTRY_DEBOUNCE_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

`ifdef CREDENTIAL_ENTRY_DEBOUNCE_EN
    localparam bit c_DB_EN = 1'b1;
`else
    localparam bit c_DB_EN = 1'b0;
`endif

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;
    logic w_level;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (c_DB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_debounce
            localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [c_CNT_W-1:0] r_db_cnt;
            logic               r_db_level;

            // Accept a new level only after it has differed for the full window.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_db_cnt   <= '0;
                    r_db_level <= 1'b0;
                end else if (r_sync2 == r_db_level) begin
                    r_db_cnt   <= '0;
                end else if (r_db_cnt == c_CNT_LAST) begin
                    r_db_cnt   <= '0;
                    r_db_level <= r_sync2;
                end else begin
                    r_db_cnt   <= r_db_cnt + 1'b1;
                end
            end

            assign w_level = r_db_level;
        end else begin : g_nodebounce
            assign w_level = r_sync2;
        end
    endgenerate

    // Registered rising-edge detect: a held button yields a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_pulse <= w_level & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/credential_entry.sv
`default_nettype none
// ============================================================================
//  Module      : credential_entry
//  Description : Collects 4 username + 4 password digits from switches, one
//                per Enter press, with Back/Clear editing and flag
//                acknowledge towards the unlocker. Optional button debounce
//                via CREDENTIAL_ENTRY_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module credential_entry
    import credential_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digitSw,
    input  logic               btnEnter,
    input  logic               btnBack,
    input  logic               btnClear,
    input  logic               btnAck,
    input  logic               resetCount,
    input  logic               flag,
    output logic [CNT_W-1:0]   inputCount,
    output logic [DIGIT_W-1:0] userNameInput0,
    output logic [DIGIT_W-1:0] userNameInput1,
    output logic [DIGIT_W-1:0] userNameInput2,
    output logic [DIGIT_W-1:0] userNameInput3,
    output logic [DIGIT_W-1:0] passwordInput0,
    output logic [DIGIT_W-1:0] passwordInput1,
    output logic [DIGIT_W-1:0] passwordInput2,
    output logic [DIGIT_W-1:0] passwordInput3,
    output logic               flagResolve
);

    localparam int c_IDX_W = $clog2(SLOTS);

    // Slot k is the k-th digit entered: slot 0 = userNameInput3 (MSB nibble),
    // slot 4 = passwordInput3, slot 7 = passwordInput0.
    logic [DIGIT_W-1:0] r_slot     [SLOTS];
    logic [DIGIT_W-1:0] w_slot_nxt [SLOTS];
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_fr;
    logic               w_fr_nxt;
    logic               r_rc_prev;

    logic               w_enter_p;
    logic               w_back_p;
    logic               w_clear_p;
    logic               w_ack_p;
    logic               w_rc_rise;
    logic               w_clear;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_bk_idx;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst(rst), .raw(btnEnter), .pulse(w_enter_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk(clk), .rst(rst), .raw(btnBack),  .pulse(w_back_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst(rst), .raw(btnClear), .pulse(w_clear_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ack (
        .clk(clk), .rst(rst), .raw(btnAck),   .pulse(w_ack_p));

    // resetCount is already in the clk domain; only its 0->1 edge matters.
    assign w_rc_rise = resetCount & ~r_rc_prev;
    assign w_clear   = w_clear_p | w_rc_rise;
    assign w_wr_idx  = r_cnt[c_IDX_W-1:0];
    assign w_bk_idx  = c_IDX_W'(r_cnt - 1'b1);

    // State register: count, digit buffer, encoded state and acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_state   <= USER;
            r_fr      <= 1'b0;
            r_rc_prev <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_state   <= w_state_nxt;
            r_fr      <= w_fr_nxt;
            r_rc_prev <= resetCount;
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= w_slot_nxt[i];
        end
    end

    // Next-state: one action per cycle, clear > ack > back > enter.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_fr_nxt  = 1'b0;
        for (int i = 0; i < SLOTS; i++) w_slot_nxt[i] = r_slot[i];

        if (w_clear) begin
            w_cnt_nxt = '0;
            for (int i = 0; i < SLOTS; i++) w_slot_nxt[i] = '0;
        end else if (w_ack_p && flag) begin
            w_fr_nxt  = 1'b1;
            w_cnt_nxt = '0;
            for (int i = 0; i < SLOTS; i++) w_slot_nxt[i] = '0;
        end else if (w_back_p && !flag && (r_cnt != '0)) begin
            w_cnt_nxt            = r_cnt - 1'b1;
            w_slot_nxt[w_bk_idx] = '0;
        end else if (w_enter_p && !flag && (r_state != FULL)) begin
            w_cnt_nxt            = r_cnt + 1'b1;
            w_slot_nxt[w_wr_idx] = digitSw;
        end

        w_state_nxt = state_of(w_cnt_nxt);
    end

    // Outputs: map slots onto the unlocker's nibble ports.
    always_comb begin
        inputCount     = r_cnt;
        flagResolve    = r_fr;
        userNameInput3 = r_slot[0];
        userNameInput2 = r_slot[1];
        userNameInput1 = r_slot[2];
        userNameInput0 = r_slot[3];
        passwordInput3 = r_slot[4];
        passwordInput2 = r_slot[5];
        passwordInput1 = r_slot[6];
        passwordInput0 = r_slot[7];
    end

endmodule
`default_nettype wire

// File: tb/tb_credential_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_credential_entry
//  Description : Directed self-checking bench for credential_entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_credential_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digitSw;
    logic       btnEnter, btnBack, btnClear, btnAck;
    logic       resetCount, flag;
    logic [3:0] inputCount;
    logic [3:0] userNameInput0, userNameInput1, userNameInput2, userNameInput3;
    logic [3:0] passwordInput0, passwordInput1, passwordInput2, passwordInput3;
    logic       flagResolve;

    int n_cmp = 0;
    int n_bad = 0;
    int fr_hits = 0;

    always #5 clk = ~clk;

    credential_entry dut (
        .clk(clk), .rst(rst), .digitSw(digitSw),
        .btnEnter(btnEnter), .btnBack(btnBack), .btnClear(btnClear), .btnAck(btnAck),
        .resetCount(resetCount), .flag(flag),
        .inputCount(inputCount),
        .userNameInput0(userNameInput0), .userNameInput1(userNameInput1),
        .userNameInput2(userNameInput2), .userNameInput3(userNameInput3),
        .passwordInput0(passwordInput0), .passwordInput1(passwordInput1),
        .passwordInput2(passwordInput2), .passwordInput3(passwordInput3),
        .flagResolve(flagResolve)
    );

    wire [15:0] user_w = {userNameInput3, userNameInput2, userNameInput1, userNameInput0};
    wire [15:0] pass_w = {passwordInput3, passwordInput2, passwordInput1, passwordInput0};

    // Count every cycle the acknowledge is high, sampled mid-cycle.
    always @(negedge clk) if (flagResolve) fr_hits++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0=enter 1=back 2=clear 3=ack
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btnEnter = v;
            1: btnBack  = v;
            2: btnClear = v;
            default: btnAck = v;
        endcase
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_btn(b, 1'b0);
        settle();
    endtask

    task automatic enter(input logic [3:0] d);
        digitSw = d;
        press(0);
    endtask

    initial begin
        rst = 1'b1; digitSw = '0;
        btnEnter = 0; btnBack = 0; btnClear = 0; btnAck = 0;
        resetCount = 0; flag = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_cnt",  inputCount, 0);
        check("reset_user", user_w, 0);
        check("reset_pass", pass_w, 0);
        check("reset_fr",   flagResolve, 0);

        // Fill all eight slots.
        for (int i = 1; i <= 8; i++) begin
            enter(4'(i));
            check("fill_cnt", inputCount, i);
        end
        check("fill_user", user_w, 32'h1234);
        check("fill_pass", pass_w, 32'h5678);
        enter(4'h9);
        check("full_cnt",  inputCount, 8);
        check("full_pass", pass_w, 32'h5678);

        // Clear, refill to 5, back twice.
        press(2);
        check("clr_cnt",  inputCount, 0);
        check("clr_user", user_w, 0);
        for (int i = 1; i <= 5; i++) enter(4'(i));
        check("five_cnt", inputCount, 5);
        press(1);
        press(1);
        check("back_cnt",  inputCount, 3);
        check("back_pw3",  passwordInput3, 0);
        check("back_un0",  userNameInput0, 0);
        check("back_user", user_w, 32'h1230);
        for (int i = 0; i < 4; i++) press(1);
        check("back_zero_cnt",  inputCount, 0);
        check("back_zero_user", user_w, 0);

        // Held Enter yields one increment.
        digitSw = 4'h7;
        btnEnter = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        btnEnter = 1'b0;
        settle();
        check("hold_cnt", inputCount, 1);
        check("hold_un3", userNameInput3, 7);

        // resetCount rising edge at full count; level held high.
        for (int i = 2; i <= 8; i++) enter(4'(i));
        check("refill_cnt", inputCount, 8);
        resetCount = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rc_cnt",  inputCount, 0);
        check("rc_pass", pass_w, 0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        enter(4'hA);
        check("rc_hold_cnt", inputCount, 1);
        check("rc_hold_un3", userNameInput3, 4'hA);
        resetCount = 1'b0;

        // Flag handling.
        flag = 1'b1;
        enter(4'h3);
        check("flag_enter_cnt", inputCount, 1);
        press(1);
        check("flag_back_cnt", inputCount, 1);
        fr_hits = 0;
        press(3);
        check("ack_pulses", fr_hits, 1);
        check("ack_cnt",    inputCount, 0);
        check("ack_user",   user_w, 0);
        flag = 1'b0;
        fr_hits = 0;
        press(3);
        check("ack_noflag", fr_hits, 0);

        // Simultaneous Back and Enter: Back wins.
        enter(4'h1);
        enter(4'h2);
        digitSw = 4'h9;
        btnEnter = 1'b1;
        btnBack  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        btnEnter = 1'b0;
        btnBack  = 1'b0;
        settle();
        check("simul_cnt",  inputCount, 1);
        check("simul_user", user_w, 32'h1000);

        // Reset mid-entry.
        for (int i = 0; i < 5; i++) enter(4'hC);
        check("pre_rst_cnt", inputCount, 6);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_cnt",  inputCount, 0);
        check("rst_user", user_w, 0);
        check("rst_pass", pass_w, 0);
        check("rst_fr",   flagResolve, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
